run_seq_gen: RTL and testbench
==============================

Name: run_seq_gen

Overview:
- Serial stimulus transmitter: the transmit end of the single-bit "a" line watched by the team's repeated-bit detector FSM (x = current bit equals previous bit; y = third or later equal bit in a row).
- Accepts run requests (bit value, run length) over a valid/ready handshake and drives them out serially, one bit per clock.
- In parallel, produces the x/y values a correct detector must show on the same cycle (x_exp/y_exp). Benches and self-test logic use these for scoreboarding.

Parameters:
- LEN_W, 4, width of req_len; maximum run length is 2^LEN_W-1.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  run request present.
- req_ready  output  1  block can accept a request this cycle.
- req_bit  input  1  bit value of the requested run.
- req_len  input  LEN_W  number of bits to emit; 0 is legal.
- a_out  output  1  serial line to the detector input "a".
- a_valid  output  1  a_out carries a requested bit this cycle.
- a_last  output  1  final bit of the current run.
- busy  output  1  run in progress.
- x_exp  output  1  expected detector x for the current a_out.
- y_exp  output  1  expected detector y for the current a_out.

Behaviour:
Reset:
- State IDLE, cnt=0, a_out=0, a_valid=0, a_last=0, busy=0, req_ready=1.
- History regs cleared: prev=0, run=0, so x_exp=0 and y_exp=0.
- Reset mid-run aborts the run immediately. No a_last is issued for the aborted run.

States:
- IDLE:
  - req_ready=1.
  - On accept (req_valid & req_ready) with req_len!=0: go to SEND next cycle, a_out<=req_bit, cnt<=req_len-1.
  - On accept with req_len=0: go to DROP. a_out holds.
- SEND:
  - a_valid=1, busy=1, a_last=(cnt==0).
  - While cnt!=0: decrement cnt each cycle; a_out is held.
  - When cnt==0: req_ready=1. A same-cycle accept starts the next run with no gap (back-to-back). Otherwise go to IDLE.
- DROP:
  - One cycle long: a_valid=0, a_last=0, busy=1, req_ready=0.
  - Returns to IDLE. No bits emitted.

Line behaviour:
- a_out is registered.
- Outside SEND, a_out holds the last transmitted value and is never re-driven, because the detector samples every cycle.

History and expected outputs:
- run is 2 bits and saturates at 2. prev is 1 bit.
- Both update on every clock, regardless of state:
  - run <= (run!=0 && a_out==prev) ? min(run+1, 2) : 1
  - prev <= a_out
- x_exp = (run!=0) & (a_out==prev) — combinational from registers, zero latency.
- y_exp = (run==2) & (a_out==prev).
- Idle cycles count as repeated bits, identical to the detector. Two idle cycles after a run of 1 therefore raise x_exp and then y_exp.

Width rules:
- cnt is LEN_W bits.
- A max-length request emits exactly 2^LEN_W-1 bits. No wrap.

Simultaneous events:
- Accept on the a_last cycle takes priority over the return to IDLE.
- req_valid deasserting without an accept has no effect.
- req_bit and req_len are sampled only on accept.

Decomposition:
- Shared package run_seq_pkg holds:
  - state enum {IDLE, SEND, DROP}
  - RUN_SAT=2
  - LEN_W default
- One natural sub-module, run_hist_model: the prev/run registers and the x_exp/y_exp logic. The same model can be reused by the detector's checker.

Test Plan:
- Reset release, no requests: a_out=0; x_exp/y_exp = 0,0 on cycle 1, then 1,0 on cycle 2, then 1,1 from cycle 3 on.
- Request (1,3) from idle on a zero line: a_out=1 for 3 cycles; a_valid=1 throughout; a_last on the 3rd; x_exp=0,1,1; y_exp=0,0,1.
- Back-to-back (0,2) then (1,1), with req_valid held: no gap cycle. a_out=0,0,1. req_ready=1 only on the a_last cycles. x_exp=0,1,0 when following a 1-line.
- req_len=0: accepted; one DROP cycle with busy=1 and req_ready=0; a_valid never asserts; a_out unchanged.
- Max length (LEN_W=4, len=15): exactly 15 a_valid cycles, a_last on cycle 15, y_exp held from the 3rd bit.
- Reset asserted on the 2nd bit of a run of 5: all outputs return to reset values asynchronously; after release, a_valid stays 0 until the next accept.

Source files
------------

// File: rtl/run_seq_gen_pkg.sv
// Shared types and constants for the run sequence generator and its history model.
package run_seq_pkg;

  localparam int LEN_W_DEF = 4;
  localparam int RUN_SAT   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } state_t;

endpackage

// File: rtl/run_seq_gen_hist_model.sv
// Line history (previous bit, saturating repeat count) and the x/y values a
// correct repeated-bit detector shows for the current line value.
module run_hist_model
  import run_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  output logic x,
  output logic y
);

  localparam logic [1:0] SAT = 2'(RUN_SAT);

  logic       prev_q, prev_d;
  logic [1:0] run_q, run_d;
  logic       same;

  always_comb begin
    same   = (a == prev_q);
    x      = (run_q != 2'd0) && same;
    y      = (run_q == SAT) && same;
    prev_d = a;
    run_d  = 2'd1;
    if (x) begin
      run_d = (run_q == SAT) ? SAT : run_q + 2'd1;
    end
  end

  // Runs every cycle: idle cycles are repeats of the held line value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
      run_q  <= 2'd0;
    end else begin
      prev_q <= prev_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/run_seq_gen.sv
// Serial run transmitter: accepts (bit, length) requests and emits one bit per
// clock on a_out, alongside the detector outputs expected for that line.
//
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both high; req_bit/req_len are sampled only then, and req_valid may drop
// at any time before a transfer without effect.
module run_seq_gen
  import run_seq_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_bit,
  input  logic [LEN_W-1:0] req_len,
  output logic             a_out,
  output logic             a_valid,
  output logic             a_last,
  output logic             busy,
  output logic             x_exp,
  output logic             y_exp,
  output state_t           state_dbg
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    req_ready = 1'b0;
    a_valid   = 1'b0;
    a_last    = 1'b0;
    busy      = 1'b0;

    case (state_q)
      IDLE: req_ready = 1'b1;
      SEND: begin
        a_valid = 1'b1;
        busy    = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LEN_W'(1);
        end else begin
          a_last    = 1'b1;
          req_ready = 1'b1;
          state_d   = IDLE;
        end
      end
      DROP: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An accept on the last bit overrides the return to IDLE (no gap cycle).
    if (req_valid && req_ready) begin
      if (req_len != '0) begin
        state_d = SEND;
        a_d     = req_bit;
        cnt_d   = req_len - LEN_W'(1);
      end else begin
        state_d = DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
    end
  end

  assign a_out     = a_q;
  assign state_dbg = state_q;

  run_hist_model u_hist (
    .clk   (clk),
    .reset (reset),
    .a     (a_q),
    .x     (x_exp),
    .y     (y_exp)
  );

endmodule

// File: tb/tb_run_seq_gen.sv
// Directed and random stimulus for run_seq_gen with a scoreboard of expected
// line bits and an independent model of the expected detector outputs.
module tb_run_seq_gen;
  import run_seq_pkg::*;

  localparam int LEN_W = 4;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_bit;
  logic [LEN_W-1:0] req_len;
  logic             a_out;
  logic             a_valid;
  logic             a_last;
  logic             busy;
  logic             x_exp;
  logic             y_exp;
  state_t           state_dbg;

  int total = 0;
  int bad   = 0;

  // Each entry: {expected a_out, expected a_last} for one a_valid cycle.
  logic [1:0] exp_q[$];

  // Bench-side line model used to predict x/y.
  logic m_line = 1'b0;
  logic m_prev = 1'b0;
  int   m_run  = 0;

  run_seq_gen #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bit   (req_bit),
    .req_len   (req_len),
    .a_out     (a_out),
    .a_valid   (a_valid),
    .a_last    (a_last),
    .busy      (busy),
    .x_exp     (x_exp),
    .y_exp     (y_exp),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and x/y model, sampled mid-cycle.
  always @(negedge clk) begin
    logic cur;
    logic ex, ey;
    logic [1:0] e;
    if (!reset) begin
      exp_q.delete();
      m_line = 1'b0;
      m_prev = 1'b0;
      m_run  = 0;
    end else begin
      cur = m_line;
      if (a_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'd0, a_valid}, 32'd0);
        end else begin
          e   = exp_q.pop_front();
          cur = e[1];
          chk("sb_a_out", {31'd0, a_out}, {31'd0, e[1]});
          chk("sb_a_last", {31'd0, a_last}, {31'd0, e[0]});
        end
      end else begin
        chk("idle_a_last", {31'd0, a_last}, 32'd0);
        chk("idle_a_hold", {31'd0, a_out}, {31'd0, m_line});
      end
      ex = (m_run > 0) && (cur == m_prev);
      ey = (m_run >= 2) && (cur == m_prev);
      chk("model_x", {31'd0, x_exp}, {31'd0, ex});
      chk("model_y", {31'd0, y_exp}, {31'd0, ey});
      m_run  = ex ? ((m_run >= 2) ? 2 : m_run + 1) : 1;
      m_prev = cur;
      m_line = cur;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_req(input logic b, input int len, output int waited);
    waited    = 0;
    req_valid = 1'b1;
    req_bit   = b;
    req_len   = len[LEN_W-1:0];
    @(negedge clk);
    while (!req_ready && waited < 60) begin
      waited++;
      @(negedge clk);
    end
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    if (req_ready) begin
      for (int k = 0; k < len; k++) exp_q.push_back({b, (k == len - 1)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_bit   = 1'($urandom_range(0, 1));
    req_len   = LEN_W'($urandom_range(0, 15));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_out"},   {31'd0, a_out},     32'd0);
    chk({tag, "_a_valid"}, {31'd0, a_valid},   32'd0);
    chk({tag, "_a_last"},  {31'd0, a_last},    32'd0);
    chk({tag, "_busy"},    {31'd0, busy},      32'd0);
    chk({tag, "_ready"},   {31'd0, req_ready}, 32'd1);
    chk({tag, "_x"},       {31'd0, x_exp},     32'd0);
    chk({tag, "_y"},       {31'd0, y_exp},     32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int n;
    reset = 1'b0;
    idle_req();

    // Reset state, then idle history ramp after release.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    chk("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    #1 reset = 1'b1;
    @(negedge clk);
    chk("ramp1_x", {31'd0, x_exp}, 32'd0);
    chk("ramp1_y", {31'd0, y_exp}, 32'd0);
    @(negedge clk);
    chk("ramp2_x", {31'd0, x_exp}, 32'd1);
    chk("ramp2_y", {31'd0, y_exp}, 32'd0);
    @(negedge clk);
    chk("ramp3_x", {31'd0, x_exp}, 32'd1);
    chk("ramp3_y", {31'd0, y_exp}, 32'd1);
    @(posedge clk);
    #1;

    // Run (1,3) from an idle zero line.
    send_req(1'b1, 3, w);
    idle_req();
    @(negedge clk);
    chk("r13_b1", {28'd0, a_out, a_valid, a_last, busy}, 32'b1101);
    chk("r13_b1_xy", {30'd0, x_exp, y_exp}, 32'b00);
    chk("r13_b1_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("r13_b2", {28'd0, a_out, a_valid, a_last, busy}, 32'b1101);
    chk("r13_b2_xy", {30'd0, x_exp, y_exp}, 32'b10);
    @(negedge clk);
    chk("r13_b3", {28'd0, a_out, a_valid, a_last, busy}, 32'b1111);
    chk("r13_b3_xy", {30'd0, x_exp, y_exp}, 32'b11);
    chk("r13_b3_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("r13_after", {28'd0, a_out, a_valid, a_last, busy}, 32'b1000);
    @(posedge clk);
    #1;

    // Back-to-back (0,2) then (1,1) with req_valid held.
    send_req(1'b0, 2, w);
    chk("b2b_first_wait", w, 0);
    send_req(1'b1, 1, w);
    chk("b2b_second_wait", w, 1);
    idle_req();
    @(negedge clk);
    chk("b2b_nogap", {28'd0, a_out, a_valid, a_last, busy}, 32'b1111);
    chk("b2b_x", {31'd0, x_exp}, 32'd0);
    @(posedge clk);
    #1;

    // Zero-length request: one DROP cycle, line untouched.
    send_req(1'b0, 0, w);
    idle_req();
    @(negedge clk);
    chk("drop_state", {30'd0, state_dbg}, {30'd0, DROP});
    chk("drop_out", {28'd0, a_out, a_valid, a_last, busy}, 32'b1001);
    chk("drop_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("drop_done", {29'd0, a_valid, busy, req_ready}, 32'b001);
    @(posedge clk);
    #1;

    // Maximum length run.
    send_req(1'b0, 15, w);
    idle_req();
    n = 0;
    @(negedge clk);
    while (a_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("max_len_count", n, 15);
    @(posedge clk);
    #1;

    // Reset on the 2nd bit of a run of 5.
    send_req(1'b1, 5, w);
    idle_req();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #2 reset = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_valid) n++;
    end
    chk("post_rst_valid", n, 0);
    @(posedge clk);
    #1;

    // Random requests with optional idle gaps.
    for (int i = 0; i < 10; i++) begin
      send_req(1'($urandom_range(0, 1)), $urandom_range(0, 6), w);
      if ($urandom_range(0, 1) == 1) begin
        idle_req();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle_req();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    chk("final_busy", {31'd0, busy}, 32'd0);
    chk("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
